// File: rtl/mc_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_ctrl_if : control bus between mc_ctrl and the datapath        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mc_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_src;
    logic        alu_src_imm;
    logic [1:0]  alu_op;
    logic        mem_we;
    logic [1:0]  ext_mode;
    logic [2:0]  state;
    logic        instr_done;
    logic        illegal;

    modport master (
        input  instr, zero,
        output pc_we, pc_src, ir_we, reg_we, reg_dst, wd_src, alu_src_imm,
               alu_op, mem_we, ext_mode, state, instr_done, illegal
    );

    modport slave (
        output instr, zero,
        input  pc_we, pc_src, ir_we, reg_we, reg_dst, wd_src, alu_src_imm,
               alu_op, mem_we, ext_mode, state, instr_done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mc_ctrl (
    input  wire logic clk,
    input  wire logic reset,
    mc_ctrl_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_MEMWB  = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_rtype, w_addu, w_subu, w_jr, w_nop;
    logic       w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal, w_legal;

    logic       w_pc_we, w_ir_we, w_reg_we, w_mem_we, w_alu_src_imm;
    logic       w_instr_done, w_illegal;
    logic [1:0] w_pc_src, w_reg_dst, w_wd_src, w_alu_op, w_ext_mode;

    assign w_op    = bus.instr[31:26];
    assign w_funct = bus.instr[5:0];
    assign w_rtype = (w_op == OP_RTYPE);
    assign w_addu  = w_rtype && (w_funct == FN_ADDU);
    assign w_subu  = w_rtype && (w_funct == FN_SUBU);
    assign w_jr    = w_rtype && (w_funct == FN_JR);
    assign w_nop   = w_rtype && !(w_addu || w_subu || w_jr);
    assign w_ori   = (w_op == OP_ORI);
    assign w_lw    = (w_op == OP_LW);
    assign w_sw    = (w_op == OP_SW);
    assign w_beq   = (w_op == OP_BEQ);
    assign w_lui   = (w_op == OP_LUI);
    assign w_j     = (w_op == OP_J);
    assign w_jal   = (w_op == OP_JAL);
    assign w_legal = w_rtype || w_ori || w_lw || w_sw || w_beq || w_lui || w_j || w_jal;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Encodings 6 and 7 fall into the default arm and recover to FETCH.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: if (w_addu || w_subu || w_ori || w_lui || w_lw || w_sw || w_beq)
                          w_next_state = S_EXEC;
            S_EXEC:   if (w_addu || w_subu || w_ori || w_lui) w_next_state = S_WB;
                      else if (w_lw || w_sw)                  w_next_state = S_MEM;
            S_MEM:    if (w_lw) w_next_state = S_MEMWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_we       = 1'b0;
        w_pc_src      = 2'd0;
        w_ir_we       = 1'b0;
        w_reg_we      = 1'b0;
        w_reg_dst     = 2'd0;
        w_wd_src      = 2'd0;
        w_alu_src_imm = 1'b0;
        w_alu_op      = 2'd0;
        w_mem_we      = 1'b0;
        w_instr_done  = 1'b0;
        w_illegal     = 1'b0;
        w_ext_mode    = 2'd0;
        if (r_state != S_FETCH) begin
            if (w_lui)                      w_ext_mode = 2'd2;
            else if (w_lw || w_sw || w_beq) w_ext_mode = 2'd1;
        end
        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_pc_we = 1'b1;
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = 2'd2;
                end
                if (w_jal) begin
                    w_reg_we  = 1'b1;
                    w_reg_dst = 2'd2;
                    w_wd_src  = 2'd2;
                end
                if (w_jr) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = 2'd3;
                end
                w_illegal    = !w_legal;
                w_instr_done = w_j || w_jal || w_jr || w_nop || !w_legal;
            end
            S_EXEC: begin
                w_alu_src_imm = w_ori || w_lui || w_lw || w_sw;
                if (w_subu || w_beq)     w_alu_op = 2'd1;
                else if (w_ori || w_lui) w_alu_op = 2'd2;
                if (w_beq) begin
                    w_pc_src     = 2'd1;
                    w_pc_we      = bus.zero;
                    w_instr_done = 1'b1;
                end
            end
            S_MEM: begin
                w_mem_we     = w_sw;
                w_instr_done = w_sw;
            end
            S_MEMWB: begin
                w_reg_we     = 1'b1;
                w_wd_src     = 2'd1;
                w_instr_done = 1'b1;
            end
            S_WB: begin
                w_reg_we     = 1'b1;
                w_reg_dst    = w_rtype ? 2'd1 : 2'd0;
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset suppresses every write and pulse regardless of the state held.
        if (reset) begin
            w_pc_we      = 1'b0;
            w_ir_we      = 1'b0;
            w_reg_we     = 1'b0;
            w_mem_we     = 1'b0;
            w_instr_done = 1'b0;
            w_illegal    = 1'b0;
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.pc_src      = w_pc_src;
    assign bus.ir_we       = w_ir_we;
    assign bus.reg_we      = w_reg_we;
    assign bus.reg_dst     = w_reg_dst;
    assign bus.wd_src      = w_wd_src;
    assign bus.alu_src_imm = w_alu_src_imm;
    assign bus.alu_op      = w_alu_op;
    assign bus.mem_we      = w_mem_we;
    assign bus.ext_mode    = w_ext_mode;
    assign bus.state       = r_state;
    assign bus.instr_done  = w_instr_done;
    assign bus.illegal     = w_illegal;
endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mc_ctrl : mc_ctrl driving a small behavioural datapath,       |
// | compared against an instruction-level reference. Rev 1.0         |
// +------------------------------------------------------------------+
module tb_mc_ctrl;
    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_NOP = 3, C_ORI = 4, C_LW = 5;
    localparam int C_SW = 6, C_BEQ = 7, C_LUI = 8, C_J = 9, C_JAL = 10, C_ILL = 11;
    localparam int N_RANDOM = 400;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_src_imm;
        logic [1:0] alu_op;
        logic       mem_we;
        logic [1:0] ext_mode;
        logic [2:0] state;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset;
    mc_ctrl_if bus ();

    mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_checks, n_errors;

    // ---------------- behavioural datapath ----------------
    logic        dp_clr;
    logic [31:0] fetch_word;
    logic [31:0] dp_pc, dp_ir, aluout, mdr;
    logic [31:0] dp_gpr [32];
    logic [31:0] dp_mem [256];
    logic [31:0] rs_val, rt_val, ext_val, alu_b, alu_res, wd;
    logic [4:0]  dst;

    always_comb begin
        rs_val = dp_gpr[dp_ir[25:21]];
        rt_val = dp_gpr[dp_ir[20:16]];
        case (bus.ext_mode)
            2'd0:    ext_val = {16'h0, dp_ir[15:0]};
            2'd1:    ext_val = {{16{dp_ir[15]}}, dp_ir[15:0]};
            2'd2:    ext_val = {dp_ir[15:0], 16'h0};
            default: ext_val = 32'h0;
        endcase
        alu_b = bus.alu_src_imm ? ext_val : rt_val;
        case (bus.alu_op)
            2'd0:    alu_res = rs_val + alu_b;
            2'd1:    alu_res = rs_val - alu_b;
            2'd2:    alu_res = rs_val | alu_b;
            default: alu_res = 32'h0;
        endcase
        case (bus.reg_dst)
            2'd0:    dst = dp_ir[20:16];
            2'd1:    dst = dp_ir[15:11];
            default: dst = 5'd31;
        endcase
        case (bus.wd_src)
            2'd0:    wd = aluout;
            2'd1:    wd = mdr;
            default: wd = dp_pc;
        endcase
    end

    assign bus.instr = dp_ir;
    assign bus.zero  = (alu_res == 32'h0);

    always @(posedge clk) begin
        if (dp_clr) begin
            dp_pc  <= 32'h0;
            dp_ir  <= 32'h0;
            aluout <= 32'h0;
            mdr    <= 32'h0;
            for (int i = 0; i < 32; i++)  dp_gpr[i] <= 32'h0;
            for (int i = 0; i < 256; i++) dp_mem[i] <= 32'h0;
        end else begin
            aluout <= alu_res;
            mdr    <= dp_mem[aluout[9:2]];
            if (bus.ir_we) dp_ir <= fetch_word;
            if (bus.pc_we) begin
                case (bus.pc_src)
                    2'd0:    dp_pc <= dp_pc + 32'd4;
                    2'd1:    dp_pc <= dp_pc + {ext_val[29:0], 2'b00};
                    2'd2:    dp_pc <= {dp_pc[31:28], dp_ir[25:0], 2'b00};
                    default: dp_pc <= rs_val;
                endcase
            end
            if (bus.mem_we) dp_mem[aluout[9:2]] <= rt_val;
            if (bus.reg_we && dst != 5'd0) dp_gpr[dst] <= wd;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_gpr [32];
    logic [31:0] m_mem [256];

    function automatic int cls(input logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                if (w[5:0] == 6'h21)      return C_ADDU;
                else if (w[5:0] == 6'h23) return C_SUBU;
                else if (w[5:0] == 6'h08) return C_JR;
                else                      return C_NOP;
            end
            6'h0D:   return C_ORI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h0F:   return C_LUI;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // sw occupies FETCH, DECODE, EXEC and MEM, so it retires in its fourth cycle.
    function automatic int latency(input int c);
        case (c)
            C_J, C_JAL, C_JR, C_NOP, C_ILL: return 2;
            C_BEQ:                          return 3;
            C_LW:                           return 5;
            default:                        return 4;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input logic [31:0] w, input int k, input logic taken);
        ctrl_t e;
        int    c;
        e = '0;
        c = cls(w);
        if (k == 0) begin
            e.ir_we = 1'b1;
            e.pc_we = 1'b1;
            return e;
        end
        e.ext_mode   = (c == C_LUI) ? 2'd2 : (c == C_LW || c == C_SW || c == C_BEQ) ? 2'd1 : 2'd0;
        e.instr_done = (k == latency(c) - 1);
        case (k)
            1: begin
                e.state = 3'd1;
                if (c == C_J || c == C_JAL) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
                if (c == C_JR)  begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
                if (c == C_JAL) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_src = 2'd2; end
                e.illegal = (c == C_ILL);
            end
            2: begin
                e.state       = 3'd2;
                e.alu_src_imm = (c == C_ORI || c == C_LUI || c == C_LW || c == C_SW);
                e.alu_op      = (c == C_SUBU || c == C_BEQ) ? 2'd1 :
                                (c == C_ORI || c == C_LUI)  ? 2'd2 : 2'd0;
                if (c == C_BEQ) begin e.pc_src = 2'd1; e.pc_we = taken; end
            end
            3: begin
                if (c == C_LW || c == C_SW) begin
                    e.state  = 3'd3;
                    e.mem_we = (c == C_SW);
                end else begin
                    e.state   = 3'd5;
                    e.reg_we  = 1'b1;
                    e.reg_dst = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
                end
            end
            default: begin
                e.state  = 3'd4;
                e.reg_we = 1'b1;
                e.wd_src = 2'd1;
            end
        endcase
        return e;
    endfunction

    task automatic model_exec(input logic [31:0] w);
        logic [31:0] a, b, sx, npc, link;
        int c;
        c    = cls(w);
        a    = m_gpr[w[25:21]];
        b    = m_gpr[w[20:16]];
        sx   = {{16{w[15]}}, w[15:0]};
        npc  = m_pc + 32'd4;
        link = npc;
        case (c)
            C_ADDU: if (w[15:11] != 0) m_gpr[w[15:11]] = a + b;
            C_SUBU: if (w[15:11] != 0) m_gpr[w[15:11]] = a - b;
            C_JR:   npc = a;
            C_ORI:  if (w[20:16] != 0) m_gpr[w[20:16]] = a | {16'h0, w[15:0]};
            C_LUI:  if (w[20:16] != 0) m_gpr[w[20:16]] = {w[15:0], 16'h0};
            C_LW:   if (w[20:16] != 0) m_gpr[w[20:16]] = m_mem[8'((a + sx) >> 2)];
            C_SW:   m_mem[8'((a + sx) >> 2)] = b;
            C_BEQ:  if (a == b) npc = npc + (sx << 2);
            C_J:    npc = {npc[31:28], w[25:0], 2'b00};
            C_JAL:  begin m_gpr[31] = link; npc = {npc[31:28], w[25:0], 2'b00}; end
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_arch(input string tag);
        int gi, mi;
        gi = 0;
        mi = 0;
        for (int i = 31; i >= 0; i--)  if (dp_gpr[i] !== m_gpr[i]) gi = i;
        for (int i = 255; i >= 0; i--) if (dp_mem[i] !== m_mem[i]) mi = i;
        check({tag, "_pc"}, dp_pc, m_pc);
        check($sformatf("%s_gpr%0d", tag, gi), dp_gpr[gi], m_gpr[gi]);
        check($sformatf("%s_mem%0d", tag, mi), dp_mem[mi], m_mem[mi]);
    endtask

    // ---------------- per-cycle compare ----------------
    logic        active, chk_release, cur_taken;
    logic [31:0] cur_w;
    int          cur_k;
    ctrl_t       e;

    always @(negedge clk) begin
        if (active) begin
            e = exp_ctrl(cur_w, cur_k, cur_taken);
            check("state",      32'(bus.state),      32'(e.state));
            check("ir_we",      32'(bus.ir_we),      32'(e.ir_we));
            check("pc_we",      32'(bus.pc_we),      32'(e.pc_we));
            check("reg_we",     32'(bus.reg_we),     32'(e.reg_we));
            check("mem_we",     32'(bus.mem_we),     32'(e.mem_we));
            check("instr_done", 32'(bus.instr_done), 32'(e.instr_done));
            check("illegal",    32'(bus.illegal),    32'(e.illegal));
            check("ext_mode",   32'(bus.ext_mode),   32'(e.ext_mode));
            if (e.pc_we) check("pc_src", 32'(bus.pc_src), 32'(e.pc_src));
            if (e.reg_we) begin
                check("reg_dst", 32'(bus.reg_dst), 32'(e.reg_dst));
                check("wd_src",  32'(bus.wd_src),  32'(e.wd_src));
            end
            if (e.state == 3'd2) begin
                check("alu_src_imm", 32'(bus.alu_src_imm), 32'(e.alu_src_imm));
                check("alu_op",      32'(bus.alu_op),      32'(e.alu_op));
            end
        end
        if (chk_release) begin
            chk_release = 1'b0;
            check("release_state", 32'(bus.state), 32'd0);
            check("release_ir_we", 32'(bus.ir_we), 32'd1);
            check("release_pc_we", 32'(bus.pc_we), 32'd1);
        end
    end

    // Runs one instruction from the start of its FETCH cycle; stop_k >= 0 abandons it early.
    task automatic run_instr(input logic [31:0] w, input int stop_k);
        int n;
        n          = (stop_k >= 0) ? stop_k : latency(cls(w));
        fetch_word = w;
        cur_w      = w;
        cur_taken  = (m_gpr[w[25:21]] == m_gpr[w[20:16]]);
        active     = 1'b1;
        for (int k = 0; k < n; k++) begin
            cur_k = k;
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        if (stop_k < 0) begin
            model_exec(w);
            check_arch($sformatf("arch_%08h", w));
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn;
        rs  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        fn  = 6'($urandom);
        if (fn == 6'h21 || fn == 6'h23 || fn == 6'h08) fn = 6'h00;
        case ($urandom_range(0, 11))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            2:  return {6'h00, rs, 15'd0, 6'h08};
            3:  return {6'h00, rs, rt, rd, 5'd0, fn};
            4:  return {6'h0D, rs, rt, imm};
            5:  return {6'h23, rs, rt, imm};
            6:  return {6'h2B, rs, rt, imm};
            7:  return {6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm};
            8:  return {6'h0F, 5'd0, rt, imm};
            9:  return {6'h02, 26'($urandom)};
            10: return {6'h03, 26'($urandom)};
            default: return {6'h10 + 6'($urandom_range(0, 7)), 26'($urandom)};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        active      = 1'b0;
        chk_release = 1'b0;
        cur_w       = 32'h0;
        cur_k       = 0;
        cur_taken   = 1'b0;
        reset       = 1'b1;
        dp_clr      = 1'b1;
        fetch_word  = 32'h0;
        m_pc        = 32'h0;
        for (int i = 0; i < 32; i++)  m_gpr[i] = 32'h0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

        repeat (3) begin
            @(negedge clk);
            check("rst_pc_we",  32'(bus.pc_we),  32'd0);
            check("rst_ir_we",  32'(bus.ir_we),  32'd0);
            check("rst_reg_we", 32'(bus.reg_we), 32'd0);
            check("rst_mem_we", 32'(bus.mem_we), 32'd0);
            check("rst_done",   32'(bus.instr_done), 32'd0);
            check("rst_state",  32'(bus.state),  32'd0);
        end
        @(posedge clk);
        #1;
        dp_clr = 1'b0;
        reset  = 1'b0;

        run_instr(32'h34018000, -1);            // ori  $1,$0,0x8000
        check("ori_r1", dp_gpr[1], 32'h00008000);
        run_instr(32'h3C02FFFF, -1);            // lui  $2,0xFFFF
        check("lui_r2", dp_gpr[2], 32'hFFFF0000);
        run_instr(32'h00221821, -1);            // addu $3,$1,$2
        check("addu_r3", dp_gpr[3], 32'hFFFF8000);
        run_instr(32'h34040010, -1);            // ori  $4,$0,0x10
        run_instr(32'hAC83FFFC, -1);            // sw   $3,-4($4)
        check("sw_mem0c", dp_mem[3], 32'hFFFF8000);
        run_instr(32'h8C85FFFC, -1);            // lw   $5,-4($4)
        check("lw_r5", dp_gpr[5], 32'hFFFF8000);

        // lw $6,-4($4) abandoned by a 3-cycle reset while in MEM.
        run_instr(32'h8C86FFFC, 3);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
            check("midrst_reg_we", 32'(bus.reg_we), 32'd0);
            check("midrst_ir_we",  32'(bus.ir_we),  32'd0);
            check("midrst_pc_we",  32'(bus.pc_we),  32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        m_pc  = m_pc + 32'd4;
        check_arch("midrst");
        check("midrst_r6", dp_gpr[6], 32'h0);
        chk_release = 1'b1;

        run_instr(32'h08000C00, -1);            // j    0x3000
        check("j_pc", dp_pc, 32'h00003000);
        run_instr(32'h1000FFFF, -1);            // beq  $0,$0,-1 (taken)
        check("beq_taken_pc", dp_pc, 32'h00003000);
        run_instr(32'h1020FFFF, -1);            // beq  $1,$0,-1 (not taken)
        check("beq_nt_pc", dp_pc, 32'h00003004);
        run_instr(32'h00000000, -1);            // nop
        run_instr(32'h0C000C00, -1);            // jal  0x3000 from 0x3008
        check("jal_r31", dp_gpr[31], 32'h0000300C);
        check("jal_pc", dp_pc, 32'h00003000);
        run_instr(32'h03E00008, -1);            // jr   $31
        check("jr_pc", dp_pc, 32'h0000300C);
        run_instr(32'hFC000000, -1);            // unsupported opcode
        check("ill_pc", dp_pc, 32'h00003010);

        for (int i = 0; i < N_RANDOM; i++) run_instr(gen_instr(), -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
